// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART Tx core between NUM_REQ packet sources.
// Each packet is prefixed with the sender id; define ARB_TRAILER_EN to append an XOR checksum.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter logic [7:0]  ID_BASE        = 8'h10,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           Tx_data,
    output logic                 Tx_start,
    input  logic                 Tx_busy,
    output logic                 timeout_err
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StHdrWait,
        StData,
`ifdef ARB_TRAILER_EN
        StDataWait,
        StTrl,
        StTrlWait
`else
        StDataWait
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                last_q, last_d;
    logic                first_q, first_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                err_q, err_d;
`ifdef ARB_TRAILER_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                pick_found;
    logic [IdxW-1:0]     pick_idx;
    logic [IdxW-1:0]     cand;
    logic [IdxW-1:0]     nxt_ptr;
    logic [7:0]          lane_data;
    logic                lane_valid;
    logic                lane_last;
    logic [7:0]          hdr_byte;

    assign lane_valid = req_valid[idx_q];
    assign lane_last  = req_last[idx_q];
    assign hdr_byte   = ID_BASE + 8'(idx_q);
    assign nxt_ptr    = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        lane_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (idx_q == IdxW'(i)) lane_data = req_data[8*i +: 8];
        end
    end

    // First valid requester searching upward from the pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IdxW'((int'(ptr_q) + int'(k)) % int'(NUM_REQ));
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            last_q  <= 1'b0;
            first_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef ARB_TRAILER_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef ARB_TRAILER_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        last_d  = last_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef ARB_TRAILER_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    idx_d             = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    state_d           = StHdr;
                end
            end
            StHdr: begin
                if (!Tx_busy) begin
                    state_d = StHdrWait;
                    first_d = 1'b1;
`ifdef ARB_TRAILER_EN
                    csum_d  = hdr_byte;
`endif
                end
            end
            // Tx_busy only rises the cycle after Tx_start, so the first wait cycle is blind.
            StHdrWait: begin
                if (first_q) first_d = 1'b0;
                else if (!Tx_busy) state_d = StData;
            end
            StData: begin
                if (lane_valid && !Tx_busy) begin
                    last_d  = lane_last;
                    first_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StDataWait;
`ifdef ARB_TRAILER_EN
                    csum_d  = csum_q ^ lane_data;
`endif
                end else if (!lane_valid) begin
                    if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        err_d   = 1'b1;
                        grant_d = '0;
                        ptr_d   = nxt_ptr;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDataWait: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!Tx_busy) begin
                    if (last_q) begin
`ifdef ARB_TRAILER_EN
                        state_d = StTrl;
`else
                        state_d = StIdle;
                        grant_d = '0;
                        ptr_d   = nxt_ptr;
`endif
                    end else begin
                        state_d = StData;
                    end
                end
            end
`ifdef ARB_TRAILER_EN
            StTrl: begin
                if (!Tx_busy) begin
                    state_d = StTrlWait;
                    first_d = 1'b1;
                end
            end
            StTrlWait: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!Tx_busy) begin
                    state_d = StIdle;
                    grant_d = '0;
                    ptr_d   = nxt_ptr;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        Tx_data   = '0;
        Tx_start  = 1'b0;
        req_ready = '0;
        case (state_q)
            StHdr: begin
                if (!Tx_busy) begin
                    Tx_start = 1'b1;
                    Tx_data  = hdr_byte;
                end
            end
            StData: begin
                if (lane_valid && !Tx_busy) begin
                    Tx_start  = 1'b1;
                    Tx_data   = lane_data;
                    req_ready = grant_q;
                end
            end
`ifdef ARB_TRAILER_EN
            StTrl: begin
                if (!Tx_busy) begin
                    Tx_start = 1'b1;
                    Tx_data  = csum_q;
                end
            end
`endif
            default: ;
        endcase
    end

    assign grant       = grant_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple UART Tx busy model.
module tb_uart_tx_arbiter;

    localparam int  NReq = 4;
`ifdef ARB_TRAILER_EN
    localparam bit  Trailer = 1'b1;
`else
    localparam bit  Trailer = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [NReq-1:0] req_valid;
    logic [NReq-1:0] req_last;
    logic [8*NReq-1:0] req_data;
    logic [NReq-1:0] req_ready;
    logic [NReq-1:0] grant;
    logic [7:0]      Tx_data;
    logic            Tx_start;
    logic            Tx_busy;
    logic            timeout_err;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         tx_cnt  = 0;
    int         rdy_cnt [NReq];
    logic [7:0] exp_q [$];
    logic [7:0] exp_byte;
    bit         prev_start = 1'b0;

    int busy_cnt = 0;
    int hold_cnt = 0;
    bit fall_q   = 1'b0;
    bit bp_arm   = 1'b0;
    bit bp_fired = 1'b0;
    bit stop_drv = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ        (NReq),
        .ID_BASE        (8'h10),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .grant       (grant),
        .Tx_data     (Tx_data),
        .Tx_start    (Tx_start),
        .Tx_busy     (Tx_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // UART Tx: busy for 10 cycles per byte; optional 50-cycle stall right after a busy fall.
    always @(posedge clk) begin
        if (Tx_start) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        fall_q <= (busy_cnt == 1) && !Tx_start;
        if (!bp_arm) bp_fired <= 1'b0;
        if (hold_cnt != 0) hold_cnt <= hold_cnt - 1;
        else if (bp_arm && fall_q && !bp_fired) begin
            hold_cnt <= 50;
            bp_fired <= 1'b1;
        end
    end
    assign Tx_busy = (busy_cnt != 0) || (hold_cnt != 0);

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int l = 0; l < NReq; l++) if (req_ready[l]) rdy_cnt[l]++;
            if (req_ready != '0) begin
                check_value("ready_with_start", {31'd0, Tx_start}, 32'd1);
                check_value("ready_outside_grant", {28'd0, req_ready & ~grant}, 32'd0);
            end
            if (Tx_start) begin
                tx_cnt++;
                check_value("start_while_busy", {31'd0, Tx_busy}, 32'd0);
                check_value("start_back_to_back", {31'd0, prev_start}, 32'd0);
                check_value("grant_onehot", {31'd0, $onehot(grant)}, 32'd1);
                if (exp_q.size() == 0) begin
                    check_value("tx_extra_byte", {24'd0, Tx_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_byte = exp_q.pop_front();
                    check_value("tx_byte", {24'd0, Tx_data}, {24'd0, exp_byte});
                end
            end
            prev_start = Tx_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic push_pkt(input int lane, input logic [31:0] bytes, input int n,
                            input bit complete);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h10 + 8'(lane);
        exp_q.push_back(cs);
        for (int i = 0; i < n; i++) begin
            b = bytes[8*i +: 8];
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        if (complete && Trailer) exp_q.push_back(cs);
    endtask

    task automatic drive_lane(input int lane, input logic [31:0] bytes, input int n,
                              input bit set_last);
        int t;
        for (int i = 0; i < n; i++) begin
            req_data[8*lane +: 8] = bytes[8*i +: 8];
            req_last[lane]        = set_last && (i == n - 1);
            req_valid[lane]       = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!req_ready[lane] && t < 3000 && !stop_drv);
            if (stop_drv) break;
            if (!req_ready[lane]) check_value("ready_wait", {31'd0, req_ready[lane]}, 32'd1);
            @(posedge clk);
            #1;
        end
        req_valid[lane] = 1'b0;
        req_last[lane]  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || grant != '0 || Tx_busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_value("idle_sb_left", exp_q.size(), 32'd0);
        check_value("idle_grant", {28'd0, grant}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_value({tag, "_grant"}, {28'd0, grant}, 32'd0);
        check_value({tag, "_ready"}, {28'd0, req_ready}, 32'd0);
        check_value({tag, "_tx_start"}, {31'd0, Tx_start}, 32'd0);
        check_value({tag, "_tx_data"}, {24'd0, Tx_data}, 32'd0);
        check_value({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    endtask

    task automatic apply_reset();
        req_valid = '0;
        req_last  = '0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int snap_tx;
        int snap_rdy;
        int t;
        for (int l = 0; l < NReq; l++) rdy_cnt[l] = 0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single packet on lane 0.
        snap_rdy = rdy_cnt[0];
        push_pkt(0, 32'h0000_3CA5, 2, 1'b1);
        drive_lane(0, 32'h0000_3CA5, 2, 1'b1);
        wait_idle();
        check_value("single_ready_pulses", rdy_cnt[0] - snap_rdy, 32'd2);

        // Pointer now 1: lane 1 wins over lane 0.
        push_pkt(1, 32'h21, 1, 1'b1);
        push_pkt(0, 32'h20, 1, 1'b1);
        fork
            drive_lane(0, 32'h20, 1, 1'b1);
            drive_lane(1, 32'h21, 1, 1'b1);
        join
        wait_idle();

        // Round-robin from pointer 0; lane 0 re-requests and is served after lane 3.
        apply_reset();
        push_pkt(0, 32'hB0, 1, 1'b1);
        push_pkt(2, 32'hB2, 1, 1'b1);
        push_pkt(3, 32'hB3, 1, 1'b1);
        push_pkt(0, 32'hB4, 1, 1'b1);
        fork
            begin
                drive_lane(0, 32'hB0, 1, 1'b1);
                drive_lane(0, 32'hB4, 1, 1'b1);
            end
            drive_lane(2, 32'hB2, 1, 1'b1);
            drive_lane(3, 32'hB3, 1, 1'b1);
        join
        wait_idle();

        // Backpressure: Tx_busy stalls 50 cycles while lane 1 byte waits in DATA.
        snap_tx = tx_cnt;
        push_pkt(1, 32'h77, 1, 1'b1);
        fork
            drive_lane(1, 32'h77, 1, 1'b1);
            begin
                t = 0;
                while (tx_cnt < snap_tx + 1 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                bp_arm = 1'b1;
                t = 0;
                while (hold_cnt == 0 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                check_value("bp_stall_started", {31'd0, hold_cnt != 0}, 32'd1);
                snap_tx  = tx_cnt;
                snap_rdy = rdy_cnt[1];
                while (hold_cnt != 0) @(negedge clk);
                check_value("bp_no_start", tx_cnt - snap_tx, 32'd0);
                check_value("bp_no_ready", rdy_cnt[1] - snap_rdy, 32'd0);
                bp_arm = 1'b0;
            end
        join
        wait_idle();
        check_value("bp_one_byte", tx_cnt - snap_tx, 32'(1 + int'(Trailer)));
        check_value("bp_one_ready", rdy_cnt[1] - snap_rdy, 32'd1);

        // Timeout: lane 1 sends one non-last byte then goes quiet.
        snap_rdy = rdy_cnt[1];
        push_pkt(1, 32'h5A, 1, 1'b0);
        drive_lane(1, 32'h5A, 1, 1'b0);
        repeat (19) @(negedge clk);
        check_value("timeout_not_early", {31'd0, timeout_err}, 32'd0);
        t = 0;
        while (!timeout_err && t < 60) begin
            @(negedge clk);
            t++;
        end
        check_value("timeout_err_set", {31'd0, timeout_err}, 32'd1);
        check_value("timeout_grant_cleared", {28'd0, grant}, 32'd0);
        check_value("timeout_sb_empty", exp_q.size(), 32'd0);
        // Pointer advanced to 2 after the abort.
        push_pkt(2, 32'h99, 1, 1'b1);
        push_pkt(0, 32'h44, 1, 1'b1);
        fork
            drive_lane(0, 32'h44, 1, 1'b1);
            drive_lane(2, 32'h99, 1, 1'b1);
        join
        wait_idle();
        check_value("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);

        // Reset during DATA_WAIT of lane 3's first payload byte.
        snap_tx = tx_cnt;
        push_pkt(3, 32'hC1, 1, 1'b0);
        fork
            drive_lane(3, 32'hC2C1, 2, 1'b1);
            begin
                t = 0;
                while (tx_cnt < snap_tx + 2 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                repeat (3) @(posedge clk);
                #3 reset = 1'b0;
                #1 check_outputs_zero("midreset");
                stop_drv = 1'b1;
            end
        join
        req_valid = '0;
        req_last  = '0;
        repeat (2) @(posedge clk);
        stop_drv = 1'b0;
        #1 reset = 1'b1;
        check_value("midreset_sb_empty", exp_q.size(), 32'd0);
        repeat (15) @(posedge clk);
        #1;
        check_value("midreset_no_resend", tx_cnt - snap_tx, 32'd2);
        push_pkt(0, 32'hD0, 1, 1'b1);
        push_pkt(3, 32'hD3, 1, 1'b1);
        fork
            drive_lane(0, 32'hD0, 1, 1'b1);
            drive_lane(3, 32'hD3, 1, 1'b1);
        join
        wait_idle();

        // Checksum trailer case (trailer present only with ARB_TRAILER_EN).
        push_pkt(0, 32'h0000_0201, 2, 1'b1);
        drive_lane(0, 32'h0000_0201, 2, 1'b1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ capture/measurement modules that each send response packets to the host.
- Grants packets round-robin and prefixes each packet with the sender's module id byte (ID_BASE + requester index), the same id space the host uses for command routing.
- Sits between the requesting modules and the UART Tx core; it alone drives Tx_data and Tx_start.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_BASE, 8'h10, module id of requester 0; requester i uses ID_BASE+i (mod 256)
TIMEOUT_CYCLES, 1024, max idle cycles inside a packet before abort (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  requester i has a byte on its data lane
req_last  in  NUM_REQ  byte on lane i is the last of its packet
req_data  in  8*NUM_REQ  flattened byte lanes; lane i = bits [8*i+7:8*i]
req_ready  out  NUM_REQ  one-cycle pulse: lane i byte consumed
grant  out  NUM_REQ  one-hot owner of the transmitter, 0 when idle
Tx_data  out  8  byte to UART Tx core
Tx_start  out  1  one-cycle pulse: UART Tx latches Tx_data
Tx_busy  in  1  UART Tx busy; rises the cycle after Tx_start, falls when stop bit is done
timeout_err  out  1  sticky: a packet was aborted by timeout

Behaviour:
- Reset (reset=0, async): all outputs 0; state IDLE; round-robin pointer = 0; timeout counter = 0. Reset mid-packet drops the packet with no further Tx_start.
- States: IDLE, HDR, HDR_WAIT, DATA, DATA_WAIT.
- IDLE: if any req_valid, pick the first set index searching from pointer upward (wrapping). Set grant one-hot next cycle and go to HDR. No winner: stay.
- HDR: when Tx_busy=0, drive Tx_data=ID_BASE+i and pulse Tx_start, go to HDR_WAIT. req_ready is not pulsed for the header.
- HDR_WAIT / DATA_WAIT: ignore Tx_busy in the first cycle after Tx_start. Afterwards wait for Tx_busy=0, then go to DATA (from HDR_WAIT) or as below (from DATA_WAIT).
- DATA: when req_valid[i]=1 and Tx_busy=0, in the same cycle:
  - Tx_data=lane i;
  - pulse Tx_start and req_ready[i];
  - capture req_last[i];
  - go to DATA_WAIT.
- DATA_WAIT exit: if the captured last=1, go to IDLE, clear grant, and set pointer = i+1 mod NUM_REQ. Otherwise go to DATA.
- Latency: grant is set 1 cycle after IDLE sees req_valid. The header Tx_start follows 1 cycle later if Tx_busy=0.
- Requesters hold data, last and valid stable until req_ready. valid from non-granted lanes is ignored and never acked.
- Fairness: a requester that just finished has lowest priority. Simultaneous requests are served in index order starting at the pointer.
- Timeout counter:
  - counts cycles in DATA with req_valid[i]=0;
  - clears on every accepted byte and on leaving DATA;
  - on reaching TIMEOUT_CYCLES: set timeout_err, clear grant, advance pointer, go to IDLE, and send no further bytes.
  - The host sees a truncated packet.
- timeout_err clears only on reset.
- Tx_start is never asserted while Tx_busy=1 and never on two consecutive cycles.
- grant changes only in IDLE transitions or on abort, never mid-byte.

Optional Feature:
ARB_TRAILER_EN:
- Defined:
  - a running XOR checksum of header and all payload bytes is kept;
  - after the byte with last=1 completes, an extra state TRL sends the checksum byte (same Tx handshake), then goes to IDLE;
  - grant is held through the trailer;
  - a timeout abort sends no trailer.
- Undefined: no checksum logic or TRL state; packet ends after the last payload byte.

Test Plan:
- Single packet: req 0 sends 8'hA5, 8'h3C (last), Tx_busy modelled 10 cycles per byte -> Tx bytes 8'h10, 8'hA5, 8'h3C. Two req_ready[0] pulses, grant returns 0, pointer = 1.
- Round-robin: req 0, 2 and 3 valid simultaneously with pointer=0, one-byte packets -> header order 8'h10, 8'h12, 8'h13. Req 0 re-requesting after its packet is served after 3.
- Backpressure: Tx_busy held high 50 cycles during DATA with req_valid=1 -> no Tx_start, no req_ready until Tx_busy=0. Then exactly one byte is sent.
- Timeout: TIMEOUT_CYCLES=16; req 1 sends header plus one byte, then drops valid -> after 16 cycles timeout_err=1, grant=0, and the next requester is granted normally.
- Reset mid-packet: reset low during DATA_WAIT -> all outputs 0 immediately. After release, no pending byte is sent and arbitration restarts at pointer 0.
- ARB_TRAILER_EN: req 0 sends 8'h01, 8'h02 (last) -> Tx bytes 8'h10, 8'h01, 8'h02, 8'h13; without the macro the 8'h13 trailer is absent.
